// File: rtl/dmem_pkg.sv
// Shared types, widths and the address fault check for the data-memory responder.
// No timing of its own; pure declarations and a combinational helper function.
// No flow control here; consumers apply these to their own handshakes.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // An address faults when it is not word aligned or points past the store.
    // idx_w is log2 of the store depth in words.
    function automatic logic addr_fault(input logic [WORD_W-1:0] addr,
                                        input int unsigned       idx_w);
        logic [WORD_W-1:0] hi;
        hi = addr >> (idx_w + 2);
        return (addr[1:0] != 2'b00) || (hi != '0);
    endfunction

endpackage

// File: rtl/dmem_store_array.sv
// Word store with per-byte-lane write enables, synchronous clear and async read.
// Write lands on the rising edge; read data is combinational from the index.
// No backpressure: a write is always accepted in the cycle it is presented.
module dmem_store_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              clr_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [BE_W-1:0]   wen_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    // Clear wins over any write so a request landing on a reset edge never commits.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int b = 0; b < BE_W; b++) begin
                if (wen_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_CYCLES, returns a response pulse.
// Latency: transfer at edge t -> rsp_valid high in cycle t+WAIT_CYCLES+1.
// Backpressure: req_ready drops from accept until the response cycle has ended.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int        AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              wr_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              ready_q;
    logic              rsp_valid_q;
    logic [WORD_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    logic              transfer;
    logic              do_access;
    logic              acc_wr;
    logic [WORD_W-1:0] acc_addr;
    logic [WORD_W-1:0] acc_wdata;
    logic [BE_W-1:0]   acc_be;
    logic              acc_fault;
    logic [AW-1:0]     acc_idx;
    logic [BE_W-1:0]   store_wen;
    logic [WORD_W-1:0] store_rdata;
    logic [WORD_W-1:0] rsp_rdata_d;
    logic              rsp_err_d;

    // Access decode: with zero wait states the access uses the live request,
    // otherwise the values latched at accept time.
    always_comb begin
        transfer  = req_valid && ready_q;
        do_access = ((state_q == WAIT) && (cnt_q == 4'd0)) ||
                    ((WAIT_CYCLES == 0) && (state_q == IDLE) && transfer);
        acc_wr    = (state_q == IDLE) ? req_wr    : wr_q;
        acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
        acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
        acc_be    = (state_q == IDLE) ? req_be    : be_q;
        acc_fault = addr_fault(acc_addr, AW);
        acc_idx   = acc_addr[AW+1:2];
        store_wen = (do_access && acc_wr && !acc_fault && reset) ? acc_be : '0;
        // Loads return the word as it was before this edge's write (none for loads anyway).
        rsp_rdata_d = (acc_wr || acc_fault) ? '0 : store_rdata;
        rsp_err_d   = acc_fault;
    end

    dmem_store_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_store (
        .clk     (clk),
        .clr_i   (!reset),
        .waddr_i (acc_idx),
        .wen_i   (store_wen),
        .wdata_i (acc_wdata),
        .raddr_i (acc_idx),
        .rdata_o (store_rdata)
    );

    // Request FSM, wait counter and registered response outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (do_access) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= rsp_rdata_d;
                rsp_err_q   <= rsp_err_d;
            end
            case (state_q)
                IDLE: begin
                    if (transfer) begin
                        wr_q    <= req_wr;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        ready_q <= 1'b0;
                        cnt_q   <= CNT_INIT;
                        state_q <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a two-wait-state build and a zero-wait build
// share one clock and one request driver; sel picks which instance is exercised.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        req_valid;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;

    logic        rdy2, vld2, err2;
    logic [31:0] rd2;
    logic        rdy0, vld0, err0;
    logic [31:0] rd0;

    logic        req_ready_m, rsp_valid_m, rsp_err_m;
    logic [31:0] rsp_rdata_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid & ~sel),
        .req_ready (rdy2),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (vld2),
        .rsp_rdata (rd2),
        .rsp_err   (err2)
    );

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid & sel),
        .req_ready (rdy0),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (vld0),
        .rsp_rdata (rd0),
        .rsp_err   (err0)
    );

    assign req_ready_m = sel ? rdy0 : rdy2;
    assign rsp_valid_m = sel ? vld0 : vld2;
    assign rsp_rdata_m = sel ? rd0  : rd2;
    assign rsp_err_m   = sel ? err0 : err2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request from a negedge; returns response data, error flag,
    // negedges from accept to the response, and whether ready rose in between.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdata, output logic err,
                          output int lat, output logic rdy_seen);
        int guard;
        guard = 0;
        while (!req_ready_m && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(negedge clk);
        req_valid = 1'b0;
        lat       = 1;
        rdy_seen  = 1'b0;
        while (!rsp_valid_m && lat < 20) begin
            if (req_ready_m) rdy_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (req_ready_m) rdy_seen = 1'b1;
        rdata = rsp_rdata_m;
        err   = rsp_err_m;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdata;
        logic        err;
        logic        rdy_seen;
        int          lat;
        int          pulses;
        int          last;
        int          overlap;

        sel       = 1'b0;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        chk("rst_ready",  32'(req_ready_m), 32'd1);
        chk("rst_valid",  32'(rsp_valid_m), 32'd0);
        chk("rst_rdata",  rsp_rdata_m,      32'd0);
        chk("rst_err",    32'(rsp_err_m),   32'd0);
        chk("rst_ready0", 32'(rdy0),        32'd1);

        // 1: load from a cleared store
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rdata, err, lat, rdy_seen);
        chk("t1_lat",   32'(lat),      32'd3);
        chk("t1_rdata", rdata,         32'd0);
        chk("t1_err",   32'(err),      32'd0);
        chk("t1_busy",  32'(rdy_seen), 32'd0);

        // 2: partial store then load
        do_req(1'b1, 32'h20, 32'hDEAD_BEEF, 4'b0101, rdata, err, lat, rdy_seen);
        chk("t2_st_lat",   32'(lat), 32'd3);
        chk("t2_st_err",   32'(err), 32'd0);
        chk("t2_st_rdata", rdata,    32'd0);
        do_req(1'b0, 32'h20, 32'h0, 4'h0, rdata, err, lat, rdy_seen);
        chk("t2_ld_rdata", rdata,    32'h00AD_00EF);
        chk("t2_ld_err",   32'(err), 32'd0);

        // be==0 store is a legal no-op
        do_req(1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, rdata, err, lat, rdy_seen);
        chk("be0_err", 32'(err), 32'd0);
        do_req(1'b0, 32'h20, 32'h0, 4'h0, rdata, err, lat, rdy_seen);
        chk("be0_rdata", rdata, 32'h00AD_00EF);

        // last word in range
        do_req(1'b1, 32'h3FC, 32'hCAFE_F00D, 4'hF, rdata, err, lat, rdy_seen);
        chk("top_st_err", 32'(err), 32'd0);
        do_req(1'b0, 32'h3FC, 32'h0, 4'h0, rdata, err, lat, rdy_seen);
        chk("top_ld_rdata", rdata,    32'hCAFE_F00D);
        chk("top_ld_err",   32'(err), 32'd0);

        // 3: faults
        do_req(1'b0, 32'h22, 32'h0, 4'h0, rdata, err, lat, rdy_seen);
        chk("t3_mis_err",   32'(err), 32'd1);
        chk("t3_mis_rdata", rdata,    32'd0);
        do_req(1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, rdata, err, lat, rdy_seen);
        chk("t3_oor_err",   32'(err), 32'd1);
        chk("t3_oor_rdata", rdata,    32'd0);
        do_req(1'b0, 32'h0, 32'h0, 4'h0, rdata, err, lat, rdy_seen);
        chk("t3_w0_rdata", rdata,    32'd0);
        chk("t3_w0_err",   32'(err), 32'd0);

        // 4: req_valid held high for four back-to-back loads
        while (!req_ready_m) @(negedge clk);
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 32'h20;
        pulses    = 0;
        last      = 0;
        overlap   = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (rsp_valid_m) begin
                if (req_ready_m) overlap++;
                if (pulses > 0) chk("t4_gap", 32'(cyc - last), 32'd4);
                chk("t4_rdata", rsp_rdata_m, 32'h00AD_00EF);
                pulses++;
                last = cyc;
                if (pulses == 4) req_valid = 1'b0;
            end
        end
        chk("t4_pulses",  32'(pulses),  32'd4);
        chk("t4_overlap", 32'(overlap), 32'd0);

        // 5: reset during WAIT drops the store and its response
        while (!req_ready_m) @(negedge clk);
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 32'h40;
        req_wdata = 32'h1111_1111;
        req_be    = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b0;
        pulses    = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (cyc == 1) reset = 1'b1;
            if (rsp_valid_m) pulses++;
        end
        chk("t5_no_rsp", 32'(pulses),      32'd0);
        chk("t5_ready",  32'(req_ready_m), 32'd1);
        chk("t5_rdata",  rsp_rdata_m,      32'd0);
        do_req(1'b0, 32'h40, 32'h0, 4'h0, rdata, err, lat, rdy_seen);
        chk("t5_ld_rdata", rdata,    32'd0);
        chk("t5_ld_err",   32'(err), 32'd0);

        // 6: zero-wait build
        sel = 1'b1;
        @(negedge clk);
        do_req(1'b1, 32'h8, 32'h1234_5678, 4'hF, rdata, err, lat, rdy_seen);
        chk("t6_st_lat", 32'(lat), 32'd1);
        chk("t6_st_err", 32'(err), 32'd0);
        do_req(1'b0, 32'h8, 32'h0, 4'h0, rdata, err, lat, rdy_seen);
        chk("t6_ld_lat",   32'(lat), 32'd1);
        chk("t6_ld_rdata", rdata,    32'h1234_5678);
        do_req(1'b0, 32'h22, 32'h0, 4'h0, rdata, err, lat, rdy_seen);
        chk("t6_mis_err",   32'(err), 32'd1);
        chk("t6_mis_rdata", rdata,    32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
